// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine: reads a length-prefixed plaintext, runs KSA/PRGA in an
// external 256x8 state memory and writes the length-prefixed ciphertext.
//
// state | meaning
// IDLE  | rdy=1, waiting for en
// INIT  | s[i]=i for i=0..255
// KSA   | key scheduling, 5 cycles per i
// LEN   | read L, write ct[0]=L
// PRGA  | keystream + encrypt, 6 cycles per byte
// DONE  | one idle cycle before returning to IDLE
module arc4_encrypt (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    input  logic [7:0]  s_rddata
);
    typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, PRGA, DONE} state_t;

    state_t      state;
    logic [2:0]  ph;
    logic [7:0]  i, j, si, sj, len;
    logic [8:0]  k;
    logic [1:0]  kidx;
    logic [23:0] key_r;
    logic [7:0]  key_byte;

    always_comb begin
        case (kidx)
            2'd0:    key_byte = key_r[23:16];
            2'd1:    key_byte = key_r[15:8];
            default: key_byte = key_r[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ph    <= 3'd0;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            len   <= 8'd0;
            k     <= 9'd0;
            kidx  <= 2'd0;
            key_r <= 24'd0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    key_r <= key;
                    i     <= 8'd0;
                    j     <= 8'd0;
                    kidx  <= 2'd0;
                    ph    <= 3'd0;
                    state <= INIT;
                end
                INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j     <= 8'd0;
                        state <= KSA;
                    end
                end
                KSA: case (ph)
                    3'd0: ph <= 3'd1;
                    3'd1: begin
                        si <= s_rddata;
                        j  <= j + s_rddata + key_byte;
                        ph <= 3'd2;
                    end
                    3'd2: ph <= 3'd3;
                    3'd3: ph <= 3'd4;
                    default: begin
                        ph   <= 3'd0;
                        i    <= i + 8'd1;
                        kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                        if (i == 8'hFF) state <= LEN;
                    end
                endcase
                LEN: if (ph == 3'd0) begin
                    ph <= 3'd1;
                end else begin
                    len   <= pt_rddata;
                    i     <= 8'd0;
                    j     <= 8'd0;
                    k     <= 9'd1;
                    ph    <= 3'd0;
                    state <= (pt_rddata == 8'd0) ? DONE : PRGA;
                end
                PRGA: case (ph)
                    3'd0: begin
                        i  <= i + 8'd1;
                        ph <= 3'd1;
                    end
                    3'd1: begin
                        si <= s_rddata;
                        j  <= j + s_rddata;
                        ph <= 3'd2;
                    end
                    3'd2: begin
                        sj <= s_rddata;
                        ph <= 3'd3;
                    end
                    3'd3: ph <= 3'd4;
                    3'd4: ph <= 3'd5;
                    default: begin
                        k  <= k + 9'd1;
                        ph <= 3'd0;
                        if (k == {1'b0, len}) state <= DONE;
                    end
                endcase
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Addresses and write data follow the same-cycle read data, so they are decoded, not flopped.
    always_comb begin
        rdy       = (state == IDLE);
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        pt_addr   = 8'd0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;
        case (state)
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
            end
            KSA: case (ph)
                3'd0: s_addr = i;
                3'd1: s_addr = j + s_rddata + key_byte;
                3'd2: begin
                    s_addr   = i;
                    s_wrdata = s_rddata;
                    s_wren   = 1'b1;
                end
                3'd3: begin
                    s_addr   = j;
                    s_wrdata = si;
                    s_wren   = 1'b1;
                end
                default: ;
            endcase
            LEN: if (ph != 3'd0) begin
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
            end
            PRGA: case (ph)
                3'd0: s_addr = i + 8'd1;
                3'd1: s_addr = j + s_rddata;
                3'd2: begin
                    s_addr   = i;
                    s_wrdata = s_rddata;
                    s_wren   = 1'b1;
                end
                3'd3: begin
                    s_addr   = j;
                    s_wrdata = si;
                    s_wren   = 1'b1;
                end
                3'd4: begin
                    s_addr  = si + sj;
                    pt_addr = k[7:0];
                end
                default: begin
                    ct_addr   = k[7:0];
                    ct_wrdata = s_rddata ^ pt_rddata;
                    ct_wren   = 1'b1;
                end
            endcase
            default: ;
        endcase
    end
endmodule

// File: tb/tb_arc4_encrypt.sv
// Bench for arc4_encrypt: memory models, software ARC4 reference feeding a ct-write
// scoreboard, and cycle-accurate completion checks.
module tb_arc4_encrypt;
    logic        clk = 1'b0;
    logic        reset;
    logic        en = 1'b0;
    logic [23:0] key = 24'd0;
    logic        rdy, ct_wren, s_wren;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_wrdata, s_rddata;

    logic [7:0]  s_mem  [256];
    logic [7:0]  pt_mem [256];
    logic [7:0]  ct_mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] e;
    int total = 0, passed = 0, viol = 0, ct_writes = 0;
    int n_done;

    always #5 clk = ~clk;

    arc4_encrypt dut (
        .clk(clk), .reset(reset), .en(en), .rdy(rdy), .key(key),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata)
    );

    always @(posedge clk) begin
        if (s_wren)  s_mem[s_addr]   <= s_wrdata;
        if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
    end

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endfunction

    // Scoreboard monitor: every ct write must match the next expected (addr,data).
    always @(negedge clk) begin
        if (reset && ct_wren) begin
            ct_writes++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL ct_extra_write: addr %0d data 0x%0h, expected no write", ct_addr, ct_wrdata);
            end else begin
                e = exp_q.pop_front();
                check("ct_addr", ct_addr, e[15:8]);
                check("ct_data", ct_wrdata, e[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (s_wren && ct_wren) viol++;
            if (rdy && (s_wren || ct_wren)) viol++;
            if ($isunknown({s_addr, pt_addr, ct_addr, rdy, s_wren, ct_wren})) viol++;
        end
    end

    task automatic push_model(input logic [23:0] k, input int len);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] t, n8, ks;
        int i, j;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + kb[n % 3]) % 256;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        n8 = len[7:0];
        exp_q.push_back({8'd0, n8});
        i = 0; j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks = s[(s[i] + s[j]) % 256];
            n8 = n[7:0];
            exp_q.push_back({n8, pt_mem[n] ^ ks});
        end
    endtask

    task automatic load_pt(input int len);
        pt_mem[0] = len[7:0];
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom);
    endtask

    task automatic start_run(input logic [23:0] k);
        @(negedge clk); en = 1'b1; key = k;
        @(negedge clk); en = 1'b0;
    endtask

    // Returns the cycle number (1 = first cycle after accept) in which rdy is seen high.
    task automatic wait_done(input int poke, input logic [23:0] poke_key, output int n);
        n = 1;
        while (!rdy && n < 4000) begin
            if (poke > 0) begin
                en = (n == poke);
                if (n == poke) key = poke_key;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_run(input string name, input logic [23:0] k, input int poke,
                          input logic [23:0] poke_key);
        int len, n;
        len = pt_mem[0];
        start_run(k);
        wait_done(poke, poke_key, n);
        check({name, "_rdy_cycle"}, n, 1540 + 6 * len);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [23:0] k;
        int len;
        for (int n = 0; n < 256; n++) begin
            s_mem[n] = 8'd0; pt_mem[n] = 8'd0; ct_mem[n] = 8'd0;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #3;
        check("reset_rdy", rdy, 1);
        check("reset_s_wren", s_wren, 0);
        check("reset_ct_wren", ct_wren, 0);
        check("reset_addrs", {s_addr, pt_addr, ct_addr}, 0);
        check("reset_wrdata", {s_wrdata, ct_wrdata}, 0);
        @(negedge clk); reset = 1'b1;

        // Abort in the middle of KSA; reset must act without a clock edge.
        load_pt(4);
        start_run(24'h123456);
        repeat (799) @(negedge clk);
        check("mid_ksa_busy", rdy, 0);
        #2 reset = 1'b0;
        #1;
        check("abort_rdy", rdy, 1);
        check("abort_s_wren", s_wren, 0);
        check("abort_ct_wren", ct_wren, 0);
        @(negedge clk); reset = 1'b1;
        exp_q.delete();
        load_pt(6);
        push_model(24'hC0FFEE, 6);
        do_run("after_reset", 24'hC0FFEE, -1, 24'd0);

        // Known ARC4 vector: key "Key", plaintext "Plaintext".
        pt_mem[0] = 8'd9;
        pt_mem[1] = 8'h50; pt_mem[2] = 8'h6C; pt_mem[3] = 8'h61; pt_mem[4] = 8'h69;
        pt_mem[5] = 8'h6E; pt_mem[6] = 8'h74; pt_mem[7] = 8'h65; pt_mem[8] = 8'h78;
        pt_mem[9] = 8'h74;
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h01BB); exp_q.push_back(16'h02F3); exp_q.push_back(16'h0316);
        exp_q.push_back(16'h04E8); exp_q.push_back(16'h05D9); exp_q.push_back(16'h0640);
        exp_q.push_back(16'h07AF); exp_q.push_back(16'h080A); exp_q.push_back(16'h09D3);
        do_run("known_vector", 24'h4B6579, -1, 24'd0);

        load_pt(0);
        ct_writes = 0;
        push_model(24'hABCDEF, 0);
        do_run("len0", 24'hABCDEF, -1, 24'd0);
        check("len0_ct_writes", ct_writes, 1);

        load_pt(255);
        ct_writes = 0;
        push_model(24'h000018, 255);
        do_run("len255", 24'h000018, -1, 24'd0);
        check("len255_ct_writes", ct_writes, 256);

        // en pulsed while busy with a different key; the original key must win.
        load_pt(20);
        push_model(24'h5A17C3, 20);
        do_run("busy_en", 24'h5A17C3, 300, 24'hFFFFFF);

        // Back-to-back: en held high, key changed after acceptance of the first run.
        load_pt(5);
        push_model(24'h010203, 5);
        push_model(24'h0A0B0C, 5);
        @(negedge clk); en = 1'b1; key = 24'h010203;
        @(negedge clk); key = 24'h0A0B0C;
        wait_done(-1, 24'd0, n_done);
        check("b2b_first_rdy_cycle", n_done, 1570);
        @(negedge clk); en = 1'b0;
        check("b2b_restart", rdy, 0);
        wait_done(-1, 24'd0, n_done);
        check("b2b_second_rdy_cycle", n_done, 1570);
        check("b2b_queue_empty", exp_q.size(), 0);

        for (int r = 0; r < 4; r++) begin
            k = 24'($urandom);
            len = $urandom_range(1, 40);
            load_pt(len);
            push_model(k, len);
            do_run("random", k, -1, 24'd0);
        end

        check("invariants", viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/arc4_encrypt.md
# arc4_encrypt

ARC4 encryption engine: the writer side of the cracker's ciphertext memory. On a start request it takes a 24-bit key and reads a length-prefixed plaintext message from plaintext memory. It runs ARC4 key scheduling and keystream generation in an external 256-byte state memory. It writes the length-prefixed ciphertext into ct_mem in the exact format the cracking blocks consume.

## Interface
- No parameters; key length fixed at 3 bytes, memories 256 x 8.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- en  in  1  start request; honoured only in a cycle where rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  24  key; byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0]; sampled only on accepted en
- pt_addr  out  8  plaintext memory address
- pt_rddata  in  8  plaintext read data
- ct_addr  out  8  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write enable
- s_addr  out  8  state memory address
- s_wrdata  out  8  state write data
- s_wren  out  1  state write enable
- s_rddata  in  8  state read data

## Operation
- Message format (pt and ct): byte 0 = length L (0..255); bytes 1..L = data. ct[0] = L, written unencrypted.
- Memories are synchronous: an address driven in cycle N returns rddata valid throughout cycle N+1. A write occurs at the edge ending the cycle in which wren=1.
- States: IDLE, INIT, KSA, LEN, PRGA, DONE.
- IDLE:
  - rdy=1.
  - en=1 at an edge → latch key, clear i/j, go to INIT.
- INIT:
  - i=0..255, one write per cycle, s[i]=i.
  - 256 cycles, then KSA with i=0, j=0.
- KSA, per i = 0..255, 5 cycles:
  - C1: s_addr=i.
  - C2: si=s_rddata; j=(j+si+key[i mod 3]) mod 256; s_addr=j.
  - C3: sj=s_rddata; write s[i]=sj.
  - C4: write s[j]=si.
  - C5: idle slot; i++.
  - Correctness when i==j is required (value unchanged).
- LEN:
  - Cycle 1: pt_addr=0.
  - Cycle 2: capture L; write ct[0]=L.
  - Clear i, j, and set k=1.
- PRGA, per k = 1..L, 6 cycles:
  - C1: i=(i+1) mod 256; s_addr=i.
  - C2: si=s_rddata; j=(j+si) mod 256; s_addr=j.
  - C3: sj=s_rddata; write s[i]=sj.
  - C4: write s[j]=si.
  - C5: s_addr=(si+sj) mod 256; pt_addr=k.
  - C6: write ct[k]=s_rddata XOR pt_rddata; k++.
- L=0: PRGA is skipped and no ct write occurs beyond ct[0].
- DONE: one cycle; rdy=0 and no writes; then IDLE.
- All sums are 8-bit, wrapping modulo 256. k must not overflow at L=255; use a 9-bit counter or an equivalent.
- en is ignored while rdy=0. key changes after acceptance have no effect.

## Timing
- Reset (async, any state) → IDLE:
  - rdy=1; ct_wren=0; s_wren=0.
  - All addresses and wrdata = 0.
  - Internal i, j, k, and key register = 0.
- Reset mid-operation aborts immediately. S and ct contents are then undefined and partially written; no further writes occur.
- The accepting edge is E0. rdy=0 from cycle 1, where cycle n is the cycle after edge E(n-1).
- Cycle map:
  - INIT: cycles 1-256.
  - KSA: cycles 257-1536.
  - LEN: cycles 1537-1538.
  - PRGA: cycles 1539 to 1538+6L.
  - DONE: cycle 1539+6L.
  - rdy=1 again in cycle 1540+6L.
- At most one of s_wren/ct_wren is high in any cycle. Each write enable is a single-cycle pulse per byte.
- Back-to-back: en held high through DONE starts the next run at the first edge where rdy=1.

## Test plan
- Reset mid-KSA (cycle ~800) → rdy=1 and both wren=0 immediately (asynchronous). A fresh en then completes a normal run.
- key=0x4B6579 ("Key"), pt = 9,"Plaintext" → ct = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy high in cycle 1594.
- L=0, any key → only ct[0]=00 written; rdy high in cycle 1540; ct_wren pulsed exactly once.
- L=255, key=0x000018 → 256 ct writes. ct[1..255] match a software ARC4 model. Feeding ct to the doublecrack block recovers key 000018.
- en pulsed while busy (cycle 300) and key changed mid-run → ignored; output equals the run with the original key.
- Assertions: s_wren and ct_wren never both high; no writes while rdy=1; every s_addr, pt_addr, and ct_addr in range throughout.
